// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access width/sign codes, FSM states
// and access-size helpers.
package mem_stage_pkg;

  localparam logic [2:0] W_W  = 3'b000;
  localparam logic [2:0] W_B  = 3'b001;
  localparam logic [2:0] W_H  = 3'b010;
  localparam logic [2:0] W_D  = 3'b011;
  localparam logic [2:0] W_WU = 3'b100;
  localparam logic [2:0] W_BU = 3'b101;
  localparam logic [2:0] W_HU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } mem_state_e;

  // Low two bits carry the size; bit 2 marks an unsigned load.
  function automatic logic [3:0] access_bytes(input logic [2:0] width);
    case (width[1:0])
      2'b00:   return 4'd4;
      2'b01:   return 4'd1;
      2'b10:   return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic load_signed(input logic [2:0] width);
    return ~width[2];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and lane-replicated store data,
// plus load byte extraction with sign/zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      width,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rbuf,
  output logic [NB-1:0]   byte_en,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext
);

  always_comb begin
    int sz;
    int base;
    logic sg;
    logic [NB-1:0]   mask;
    logic [XLEN-1:0] shifted;

    sz = int'(access_bytes(width));
    if (sz > NB) sz = NB;
    // Misaligned low offset bits are dropped so the access stays in its lane group.
    base = int'(offset) & ~(sz - 1);
    sg   = load_signed(width);

    case (sz)
      1:       mask = NB'(1);
      2:       mask = NB'(3);
      4:       mask = NB'(15);
      default: mask = '1;
    endcase
    byte_en = mask << base;

    case (sz)
      1:       wdata_rep = {NB{wdata[7:0]}};
      2:       wdata_rep = {(NB/2){wdata[15:0]}};
      4:       wdata_rep = {(NB/4){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase

    shifted = rbuf >> (8 * base);
    case (sz)
      1:       rdata_ext = sg ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      2:       rdata_ext = sg ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      4:       rdata_ext = sg ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory pipeline stage with a handshaked data-memory port and busy stall.
// Optional build macro MEM_MISALIGN_TRAP_EN adds the MisalignM trap output.
//
// state   | meaning
// S_IDLE  | no request outstanding; pipeline register free to capture
// S_REQ   | request issued for the instruction held in the register
// S_DRAIN | instruction flushed, waiting out the unretractable request
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int RESULT_SRC_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [XLEN-1:0]         ALUResultE,
  input  logic [XLEN-1:0]         WriteDataE,
  input  logic [XLEN-1:0]         PCTargetE,
  input  logic [XLEN-1:0]         PCPlus4E,
  input  logic [XLEN-1:0]         ImmExtE,
  input  logic [REG_ADDR_W-1:0]   RdE,
  input  logic [2:0]              WidthSrcE,
  input  logic [RESULT_SRC_W-1:0] ResultSrcE,
  input  logic                    MemWriteE,
  input  logic                    MemReadE,
  input  logic                    RegWriteE,
  input  logic                    StallM,
  input  logic                    FlushM,
  output logic                    MemReqM,
  output logic                    MemWeM,
  output logic [XLEN-1:0]         MemAddrM,
  output logic [XLEN-1:0]         MemWDataM,
  output logic [XLEN/8-1:0]       MemByteEnM,
  input  logic [XLEN-1:0]         MemRDataM,
  input  logic                    MemAckM,
  output logic                    MemBusyM,
  output logic                    LoadValidM,
  output logic [XLEN-1:0]         ReducedDataM,
  output logic [XLEN-1:0]         ForwardDataM,
  output logic [REG_ADDR_W-1:0]   RdM,
  output logic [RESULT_SRC_W-1:0] ResultSrcM,
  output logic                    RegWriteM
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                    MisalignM
`endif
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [XLEN-1:0]         alu_q, alu_d, wd_q, wd_d, pct_q, pct_d, pc4_q, pc4_d, imm_q, imm_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [2:0]              width_q, width_d;
  logic [RESULT_SRC_W-1:0] rsrc_q, rsrc_d;
  logic                    memwr_q, memwr_d, memrd_q, memrd_d, regwr_q, regwr_d;

  logic [XLEN-1:0] hold_addr_q, hold_addr_d, hold_wdata_q, hold_wdata_d;
  logic [NB-1:0]   hold_be_q, hold_be_d;
  logic            hold_we_q, hold_we_d;

  mem_state_e      state_q;
  logic            mem_req_q, load_valid_q;
  logic [XLEN-1:0] rbuf_q;

  logic pipe_en, mem_op_e, mis_e, mem_start;
  logic [NB-1:0]   be_w;
  logic [XLEN-1:0] wdata_rep_w, rdata_ext_w;
  logic            drain;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    pipe_en  = (~StallM & ~mem_req_q) | FlushM;
    mem_op_e = MemReadE | MemWriteE;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_e = mem_op_e &&
            ((int'(ALUResultE[OFFW-1:0]) & (int'(access_bytes(WidthSrcE)) - 1)) != 0);
    misalign_d = pipe_en & ~FlushM & mis_e;
`else
    mis_e = 1'b0;
`endif
    mem_start = pipe_en & ~FlushM & mem_op_e & ~mis_e;

    alu_d = alu_q;  wd_d = wd_q;  pct_d = pct_q;  pc4_d = pc4_q;  imm_d = imm_q;
    rd_d = rd_q;  width_d = width_q;  rsrc_d = rsrc_q;
    memwr_d = memwr_q;  memrd_d = memrd_q;  regwr_d = regwr_q;
    if (FlushM) begin
      alu_d = '0;  wd_d = '0;  pct_d = '0;  pc4_d = '0;  imm_d = '0;
      rd_d = '0;  width_d = '0;  rsrc_d = '0;
      memwr_d = 1'b0;  memrd_d = 1'b0;  regwr_d = 1'b0;
    end else if (pipe_en) begin
      alu_d = ALUResultE;  wd_d = WriteDataE;  pct_d = PCTargetE;
      pc4_d = PCPlus4E;    imm_d = ImmExtE;    rd_d = RdE;
      width_d = WidthSrcE; rsrc_d = ResultSrcE;
      memwr_d = MemWriteE & ~mis_e;
      memrd_d = MemReadE & ~mis_e;
      regwr_d = RegWriteE & ~mis_e;
    end

    // Snapshot the live request every REQ cycle so a flush can't disturb it.
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_be_d    = hold_be_q;
    hold_we_d    = hold_we_q;
    if (state_q == S_REQ) begin
      hold_addr_d  = alu_q;
      hold_wdata_d = wdata_rep_w;
      hold_be_d    = memwr_q ? be_w : '0;
      hold_we_d    = memwr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q <= '0;  wd_q <= '0;  pct_q <= '0;  pc4_q <= '0;  imm_q <= '0;
      rd_q <= '0;  width_q <= '0;  rsrc_q <= '0;
      memwr_q <= 1'b0;  memrd_q <= 1'b0;  regwr_q <= 1'b0;
      hold_addr_q <= '0;  hold_wdata_q <= '0;  hold_be_q <= '0;  hold_we_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      alu_q <= alu_d;  wd_q <= wd_d;  pct_q <= pct_d;  pc4_q <= pc4_d;  imm_q <= imm_d;
      rd_q <= rd_d;  width_q <= width_d;  rsrc_q <= rsrc_d;
      memwr_q <= memwr_d;  memrd_q <= memrd_d;  regwr_q <= regwr_d;
      hold_addr_q <= hold_addr_d;  hold_wdata_q <= hold_wdata_d;
      hold_be_q <= hold_be_d;  hold_we_q <= hold_we_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      load_valid_q <= 1'b0;
      rbuf_q       <= '0;
    end else begin
      if (pipe_en) load_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_start) begin
            state_q   <= S_REQ;
            mem_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (MemAckM) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            if (memrd_q && !FlushM) begin
              rbuf_q       <= MemRDataM;
              load_valid_q <= 1'b1;
            end
          end else if (FlushM) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (MemAckM) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .offset   (alu_q[OFFW-1:0]),
    .width    (width_q),
    .wdata    (wd_q),
    .rbuf     (rbuf_q),
    .byte_en  (be_w),
    .wdata_rep(wdata_rep_w),
    .rdata_ext(rdata_ext_w)
  );

  assign drain        = (state_q == S_DRAIN);
  assign MemReqM      = mem_req_q;
  assign MemBusyM     = mem_req_q;
  assign MemWeM       = drain ? hold_we_q    : memwr_q;
  assign MemAddrM     = drain ? hold_addr_q  : alu_q;
  assign MemWDataM    = drain ? hold_wdata_q : wdata_rep_w;
  assign MemByteEnM   = drain ? hold_be_q    : (memwr_q ? be_w : '0);
  assign LoadValidM   = load_valid_q;
  assign ReducedDataM = rdata_ext_w;
  assign RdM          = rd_q;
  assign ResultSrcM   = rsrc_q;
  assign RegWriteM    = regwr_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign MisalignM    = misalign_q;
`endif

  always_comb begin
    case (rsrc_q[1:0])
      2'b00:   ForwardDataM = alu_q;
      2'b01:   ForwardDataM = pct_q;
      2'b10:   ForwardDataM = pc4_q;
      default: ForwardDataM = imm_q;
    endcase
  end

endmodule
